hack_data_memory: RTL and testbench

- Data-memory stage directly downstream of the Hack CPU. It consumes outM/writeM/addressM and returns inM.
- Memory map: 16K-word RAM, 8K-word screen buffer, and a memory-mapped keyboard register.
- The keyboard register is fed by a small keystroke FIFO with a valid/ready handshake. The CPU acknowledges a key by writing to the KBD address.
- A second read-only port exposes the screen buffer to the display logic.

---
 rtl/hack_mem_pkg.sv | 41 ++++
 rtl/hack_data_memory_kbd_fifo.sv | 71 +++++++
 rtl/hack_data_memory.sv | 113 +++++++++++
 tb/tb_hack_data_memory.sv | 503 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// Shared constants, region-select enum and address decoder for the
// Hack data memory: RAM, screen buffer, keyboard register, unmapped.
package hack_mem_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 15;

    localparam logic [ADDR_W-1:0] RAM_BASE  = 15'h0000;
    localparam logic [ADDR_W-1:0] RAM_LIMIT = 15'h3FFF;
    localparam logic [ADDR_W-1:0] SCR_BASE  = 15'h4000;
    localparam logic [ADDR_W-1:0] SCR_LIMIT = 15'h5FFF;
    localparam logic [ADDR_W-1:0] KBD_ADDR_DEFAULT = 15'h6000;

    localparam int RAM_WORDS = 16384;
    localparam int SCR_WORDS = 8192;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_SCR,
        REG_KBD,
        REG_NONE
    } region_e;

    // The keyboard address is matched first so a relocated register
    // still wins over the range checks.
    function automatic region_e decode_region(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] kbd_addr
    );
        if (addr == kbd_addr) begin
            return REG_KBD;
        end else if (addr <= RAM_LIMIT) begin
            return REG_RAM;
        end else if (addr >= SCR_BASE && addr <= SCR_LIMIT) begin
            return REG_SCR;
        end else begin
            return REG_NONE;
        end
    endfunction

endpackage

// File: rtl/hack_data_memory_kbd_fifo.sv
// Keystroke FIFO: valid/ready push side, pop strobe, head word, count.
// Ports: clk, reset (async, active low), push_valid/push_data/push_ready,
// pop, head (0 when empty), count. Zero codes complete the handshake
// but are not stored.
module hack_kbd_fifo
    import hack_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_valid,
    input  logic [WORD_W-1:0]          push_data,
    output logic                       push_ready,
    input  logic                       pop,
    output logic [WORD_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic empty;
    logic do_store;
    logic do_pop;

    assign empty      = (count_q == '0);
    assign push_ready = (count_q < CNT_W'(DEPTH));
    assign do_store   = push_valid & push_ready & (push_data != '0);
    assign do_pop     = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_store) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_store) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/hack_data_memory.sv
// Hack data memory: 16K RAM, 8K screen, keyboard FIFO register, plus a
// read-only display port. Ports: clk, reset (async, active low),
// addressM/outM/writeM -> inM, kbd_code/kbd_valid/kbd_ready/kbd_count,
// scr_addr -> scr_data. Define HACK_MEM_FAULT_EN to add the sticky
// mem_fault / fault_addr outputs for writes to unmapped addresses.
module hack_data_memory
    import hack_mem_pkg::*;
#(
    parameter int                KBD_DEPTH = 4,
    parameter logic [ADDR_W-1:0] KBD_ADDR  = KBD_ADDR_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          addressM,
    input  logic [WORD_W-1:0]          outM,
    input  logic                       writeM,
    output logic [WORD_W-1:0]          inM,
    input  logic [WORD_W-1:0]          kbd_code,
    input  logic                       kbd_valid,
    output logic                       kbd_ready,
    output logic [$clog2(KBD_DEPTH):0] kbd_count,
`ifdef HACK_MEM_FAULT_EN
    output logic                       mem_fault,
    output logic [ADDR_W-1:0]          fault_addr,
`endif
    input  logic [12:0]                scr_addr,
    output logic [WORD_W-1:0]          scr_data
);

    region_e region;

    logic [WORD_W-1:0] ram_q [RAM_WORDS];
    logic [WORD_W-1:0] scr_q [SCR_WORDS];
    logic [WORD_W-1:0] kbd_head;

    logic wr_ok;
    logic ram_we;
    logic scr_we;
    logic kbd_pop;

    assign region  = decode_region(addressM, KBD_ADDR);
    // Writes are blocked while reset is held, even mid-cycle.
    assign wr_ok   = writeM & reset;
    assign ram_we  = wr_ok & (region == REG_RAM);
    assign scr_we  = wr_ok & (region == REG_SCR);
    assign kbd_pop = wr_ok & (region == REG_KBD);

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[addressM[13:0]] <= outM;
        end
    end

    always_ff @(posedge clk) begin
        if (scr_we) begin
            scr_q[addressM[12:0]] <= outM;
        end
    end

    hack_kbd_fifo #(
        .DEPTH (KBD_DEPTH)
    ) u_kbd_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (kbd_valid),
        .push_data  (kbd_code),
        .push_ready (kbd_ready),
        .pop        (kbd_pop),
        .head       (kbd_head),
        .count      (kbd_count)
    );

    always_comb begin
        inM = '0;
        unique case (region)
            REG_RAM: inM = ram_q[addressM[13:0]];
            REG_SCR: inM = scr_q[addressM[12:0]];
            REG_KBD: inM = kbd_head;
            default: inM = '0;
        endcase
    end

    assign scr_data = scr_q[scr_addr];

`ifdef HACK_MEM_FAULT_EN
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;

    // Only the first offending address is kept until reset.
    always_comb begin
        fault_d = fault_q;
        faddr_d = faddr_q;
        if (writeM && region == REG_NONE && !fault_q) begin
            fault_d = 1'b1;
            faddr_d = addressM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
            faddr_q <= '0;
        end else begin
            fault_q <= fault_d;
            faddr_q <= faddr_d;
        end
    end

    assign mem_fault  = fault_q;
    assign fault_addr = faddr_q;
`endif

endmodule

// File: tb/tb_hack_data_memory.sv
// Self-checking bench for hack_data_memory: directed scenarios plus a
// randomized run against a queue/array reference model.
module tb_hack_data_memory;

    localparam logic [14:0] KBD = 15'h6000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] addr = '0;
    logic [15:0] outm = '0;
    logic        wr = 1'b0;
    logic [15:0] inm;
    logic [15:0] kcode = '0;
    logic        kvalid = 1'b0;
    logic        kready;
    logic [2:0]  kcount;
    logic [12:0] saddr = '0;
    logic [15:0] sdata;
`ifdef HACK_MEM_FAULT_EN
    logic        mem_fault;
    logic [14:0] fault_addr;
`endif

    int checks = 0;
    int failures = 0;

    logic [15:0] ram_m [16384];
    bit          ram_k [16384];
    logic [15:0] scr_m [8192];
    bit          scr_k [8192];
    logic [15:0] q [$];

    always #5 clk = ~clk;

    hack_data_memory dut (
        .clk        (clk),
        .reset      (reset),
        .addressM   (addr),
        .outM       (outm),
        .writeM     (wr),
        .inM        (inm),
        .kbd_code   (kcode),
        .kbd_valid  (kvalid),
        .kbd_ready  (kready),
        .kbd_count  (kcount),
`ifdef HACK_MEM_FAULT_EN
        .mem_fault  (mem_fault),
        .fault_addr (fault_addr),
`endif
        .scr_addr   (saddr),
        .scr_data   (sdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr = 1'b0;
        kvalid = 1'b0;
        kcode = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b0;
        step();
        addr = KBD;
        #1;
        checks++;
        if (kready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", kready);
        end
        checks++;
        if (kcount !== 3'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", kcount);
        end
        checks++;
        if (inm !== 16'h0) begin
            failures++;
            $display("FAIL reset_inm_kbd got=%h exp=0000", inm);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_ram();
        addr = 15; outm = 16'h1234; wr = 1'b1;
        step();
        addr = 15'h2005; outm = 16'hAAAA;
        step();
        addr = 15'h3FFF; outm = 16'hC3C3;
        step();
        addr = 15'h6005; outm = 16'h5555;
        step();
        wr = 1'b0;
        addr = 15;
        #1;
        checks++;
        if (inm !== 16'h1234) begin
            failures++;
            $display("FAIL ram_15 got=%h exp=1234", inm);
        end
        addr = 15'h6005;
        #1;
        checks++;
        if (inm !== 16'h0) begin
            failures++;
            $display("FAIL unmapped_read got=%h exp=0000", inm);
        end
        addr = 15'h2005;
        #1;
        checks++;
        if (inm !== 16'hAAAA) begin
            failures++;
            $display("FAIL unmapped_no_alias got=%h exp=aaaa", inm);
        end
        addr = 15'h3FFF;
        #1;
        checks++;
        if (inm !== 16'hC3C3) begin
            failures++;
            $display("FAIL ram_top got=%h exp=c3c3", inm);
        end
    endtask

    task automatic test_screen();
        addr = 15'h4001; outm = 16'h5A5A; wr = 1'b1;
        step();
        addr = 15'h5FFF; outm = 16'hBEEF;
        step();
        addr = 15'h4000; outm = 16'hFFFF; saddr = 13'd0;
        step();
        wr = 1'b0;
        #1;
        checks++;
        if (sdata !== 16'hFFFF) begin
            failures++;
            $display("FAIL scr_port0 got=%h exp=ffff", sdata);
        end
        checks++;
        if (inm !== 16'hFFFF) begin
            failures++;
            $display("FAIL scr_inm got=%h exp=ffff", inm);
        end
        saddr = 13'd1;
        #1;
        checks++;
        if (sdata !== 16'h5A5A) begin
            failures++;
            $display("FAIL scr_port1 got=%h exp=5a5a", sdata);
        end
        saddr = 13'h1FFF;
        #1;
        checks++;
        if (sdata !== 16'hBEEF) begin
            failures++;
            $display("FAIL scr_top got=%h exp=beef", sdata);
        end
        addr = 15'h0001;
        #1;
        checks++;
        if (inm === 16'h5A5A) begin
            failures++;
            $display("FAIL scr_ram_alias got=%h exp=not_5a5a", inm);
        end
    endtask

    task automatic test_kbd_basic();
        kvalid = 1'b1; kcode = 16'h41;
        step();
        kcode = 16'h42;
        step();
        kvalid = 1'b0;
        addr = KBD;
        #1;
        checks++;
        if (kcount !== 3'd2) begin
            failures++;
            $display("FAIL kbd_count2 got=%0d exp=2", kcount);
        end
        checks++;
        if (inm !== 16'h41) begin
            failures++;
            $display("FAIL kbd_head41 got=%h exp=0041", inm);
        end
        wr = 1'b1; outm = 16'h9999;
        step();
        wr = 1'b0;
        #1;
        checks++;
        if (inm !== 16'h42 || kcount !== 3'd1) begin
            failures++;
            $display("FAIL kbd_pop1 got=%h/%0d exp=0042/1", inm, kcount);
        end
        wr = 1'b1;
        step();
        step();
        wr = 1'b0;
        #1;
        checks++;
        if (inm !== 16'h0 || kcount !== 3'd0) begin
            failures++;
            $display("FAIL kbd_pop_empty got=%h/%0d exp=0000/0", inm, kcount);
        end
    endtask

    task automatic test_kbd_full();
        logic [15:0] exp_codes [4];
        exp_codes = '{16'h52, 16'h53, 16'h54, 16'h55};
        addr = KBD;
        kvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            kcode = 16'h51 + 16'(i);
            step();
        end
        kcode = 16'h55;
        #1;
        checks++;
        if (kcount !== 3'd4 || kready !== 1'b0) begin
            failures++;
            $display("FAIL kbd_full got=%0d/%b exp=4/0", kcount, kready);
        end
        step();
        checks++;
        if (kcount !== 3'd4) begin
            failures++;
            $display("FAIL kbd_full_hold got=%0d exp=4", kcount);
        end
        wr = 1'b1;
        step();
        wr = 1'b0;
        #1;
        checks++;
        if (kcount !== 3'd3 || kready !== 1'b1 || inm !== 16'h52) begin
            failures++;
            $display("FAIL kbd_full_pop got=%0d/%b/%h exp=3/1/0052",
                     kcount, kready, inm);
        end
        step();
        kvalid = 1'b0;
        #1;
        checks++;
        if (kcount !== 3'd4) begin
            failures++;
            $display("FAIL kbd_refill got=%0d exp=4", kcount);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (inm !== exp_codes[i]) begin
                failures++;
                $display("FAIL kbd_order%0d got=%h exp=%h",
                         i, inm, exp_codes[i]);
            end
            wr = 1'b1;
            step();
            wr = 1'b0;
            #1;
        end
        checks++;
        if (kcount !== 3'd0) begin
            failures++;
            $display("FAIL kbd_drain got=%0d exp=0", kcount);
        end
    endtask

    task automatic test_kbd_zero_empty();
        addr = KBD;
        kvalid = 1'b1; kcode = 16'h0;
        #1;
        checks++;
        if (kready !== 1'b1) begin
            failures++;
            $display("FAIL kbd_zero_ready got=%b exp=1", kready);
        end
        step();
        kvalid = 1'b0;
        #1;
        checks++;
        if (kcount !== 3'd0) begin
            failures++;
            $display("FAIL kbd_zero_push got=%0d exp=0", kcount);
        end
        kvalid = 1'b1; kcode = 16'h43; wr = 1'b1;
        step();
        idle();
        #1;
        checks++;
        if (kcount !== 3'd1 || inm !== 16'h43) begin
            failures++;
            $display("FAIL kbd_pushpop_empty got=%0d/%h exp=1/0043",
                     kcount, inm);
        end
        kvalid = 1'b1; kcode = 16'h44; wr = 1'b1;
        step();
        idle();
        #1;
        checks++;
        if (kcount !== 3'd1 || inm !== 16'h44) begin
            failures++;
            $display("FAIL kbd_pushpop_mid got=%0d/%h exp=1/0044",
                     kcount, inm);
        end
        wr = 1'b1;
        step();
        wr = 1'b0;
    endtask

    task automatic test_reset_mid();
        addr = 15'd100; outm = 16'h1111; wr = 1'b1;
        step();
        wr = 1'b0;
        kvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            kcode = 16'h61 + 16'(i);
            step();
        end
        kvalid = 1'b0;
        #1;
        checks++;
        if (kcount !== 3'd3) begin
            failures++;
            $display("FAIL mid_pre got=%0d exp=3", kcount);
        end
        #1;
        reset = 1'b0;
        addr = KBD;
        #1;
        checks++;
        if (kcount !== 3'd0 || kready !== 1'b1 || inm !== 16'h0) begin
            failures++;
            $display("FAIL mid_async got=%0d/%b/%h exp=0/1/0000",
                     kcount, kready, inm);
        end
        addr = 15'd100; outm = 16'h2222; wr = 1'b1;
        step();
        wr = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (inm !== 16'h1111) begin
            failures++;
            $display("FAIL write_in_reset got=%h exp=1111", inm);
        end
    endtask

`ifdef HACK_MEM_FAULT_EN
    task automatic test_fault();
        do_reset();
        #1;
        checks++;
        if (mem_fault !== 1'b0 || fault_addr !== 15'h0) begin
            failures++;
            $display("FAIL fault_reset got=%b/%h exp=0/0000",
                     mem_fault, fault_addr);
        end
        wr = 1'b1;
        addr = KBD;
        step();
        addr = 15'h5FFF;
        step();
        checks++;
        if (mem_fault !== 1'b0) begin
            failures++;
            $display("FAIL fault_mapped got=%b exp=0", mem_fault);
        end
        addr = 15'h7000;
        step();
        addr = 15'h7001;
        step();
        wr = 1'b0;
        checks++;
        if (mem_fault !== 1'b1 || fault_addr !== 15'h7000) begin
            failures++;
            $display("FAIL fault_sticky got=%b/%h exp=1/7000",
                     mem_fault, fault_addr);
        end
        do_reset();
        #1;
        checks++;
        if (mem_fault !== 1'b0 || fault_addr !== 15'h0) begin
            failures++;
            $display("FAIL fault_clear got=%b/%h exp=0/0000",
                     mem_fault, fault_addr);
        end
    endtask
`endif

    task automatic test_random();
        logic [15:0] exp;
        bit          known;
        bit          ready_m, pop_m, push_m;
        bit          f_m;
        logic [14:0] fa_m;
        int          sel;
        do_reset();
        q = {};
        f_m = 1'b0;
        fa_m = '0;
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)       addr = 15'($urandom_range(0, 63));
            else if (sel < 7)  addr = 15'h4000 + 15'($urandom_range(0, 63));
            else if (sel == 7) addr = KBD;
            else if (sel == 8) addr = 15'h6001 + 15'($urandom_range(0, 63));
            else               addr = 15'h7FFF;
            wr = 1'($urandom_range(0, 1));
            outm = 16'($urandom);
            kvalid = 1'($urandom_range(0, 1));
            kcode = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            saddr = 13'($urandom_range(0, 63));
            #1;
            known = 1'b1;
            exp = 16'h0;
            if (addr < 15'h4000) begin
                known = ram_k[addr];
                exp = ram_m[addr];
            end else if (addr < 15'h6000) begin
                known = scr_k[addr - 15'h4000];
                exp = scr_m[addr - 15'h4000];
            end else if (addr == KBD) begin
                exp = (q.size() > 0) ? q[0] : 16'h0;
            end
            if (known) begin
                checks++;
                if (inm !== exp) begin
                    failures++;
                    $display("FAIL rnd_inm n=%0d addr=%h got=%h exp=%h",
                             n, addr, inm, exp);
                end
            end
            if (scr_k[saddr]) begin
                checks++;
                if (sdata !== scr_m[saddr]) begin
                    failures++;
                    $display("FAIL rnd_scr n=%0d got=%h exp=%h",
                             n, sdata, scr_m[saddr]);
                end
            end
            checks++;
            if (kcount !== 3'(q.size()) || kready !== (q.size() < 4)) begin
                failures++;
                $display("FAIL rnd_kbd n=%0d got=%0d/%b exp=%0d/%b",
                         n, kcount, kready, q.size(), q.size() < 4);
            end
`ifdef HACK_MEM_FAULT_EN
            checks++;
            if (mem_fault !== f_m || fault_addr !== fa_m) begin
                failures++;
                $display("FAIL rnd_fault n=%0d got=%b/%h exp=%b/%h",
                         n, mem_fault, fault_addr, f_m, fa_m);
            end
`endif
            ready_m = q.size() < 4;
            pop_m = wr && addr == KBD && q.size() > 0;
            push_m = kvalid && ready_m && kcode != 16'h0;
            if (wr && addr < 15'h4000) begin
                ram_m[addr] = outm;
                ram_k[addr] = 1'b1;
            end else if (wr && addr >= 15'h4000 && addr < 15'h6000) begin
                scr_m[addr - 15'h4000] = outm;
                scr_k[addr - 15'h4000] = 1'b1;
            end else if (wr && addr > KBD && !f_m) begin
                f_m = 1'b1;
                fa_m = addr;
            end
            if (pop_m) void'(q.pop_front());
            if (push_m) q.push_back(kcode);
            step();
        end
        idle();
    endtask

    initial begin
        #1;
        reset = 1'b0;
        test_reset();
        test_ram();
        test_screen();
        test_kbd_basic();
        test_kbd_full();
        test_kbd_zero_empty();
        test_reset_mid();
`ifdef HACK_MEM_FAULT_EN
        test_fault();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
